// File: rtl/fft16_pkg.sv
// fft16_pkg: shared constants, FSM encoding and butterfly address helpers for the 16-point FFT scheduler
package fft16_pkg;
   localparam int LOG2N = 4;
   localparam int NPTS  = 16;
   localparam int AW    = LOG2N;
   localparam int SW    = 2;
   localparam int KW    = 3;
   localparam int TWW   = 3;
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;
   function automatic logic [KW-1:0] pos_mask(input logic [SW-1:0] s);
      return (KW'(1) << s) - 1'b1;
   endfunction
   // grp*2*span + pos: the group bits move up one place, the position bits stay put
   function automatic logic [AW-1:0] bf_addr_a(input logic [SW-1:0] s, input logic [KW-1:0] k);
      return (AW'(k & ~pos_mask(s)) << 1) | AW'(k & pos_mask(s));
   endfunction
   function automatic logic [AW-1:0] bf_addr_b(input logic [SW-1:0] s, input logic [KW-1:0] k);
      return bf_addr_a(s, k) | (AW'(1) << s);
   endfunction
   function automatic logic [TWW-1:0] bf_tw(input logic [SW-1:0] s, input logic [KW-1:0] k);
      return TWW'((k & pos_mask(s)) << (3 - s));
   endfunction
endpackage

// File: rtl/fft16_bfly_sched_if.sv
// fft16_bfly_sched_if: scheduler control bus
//   start/hold in; busy, done, stage, rd_en/rd_addr_a/rd_addr_b/tw_idx, wr_en/wr_addr_a/wr_addr_b out
//   hold exists only when FFT_SCHED_HOLD_EN is defined
interface fft16_bfly_sched_if;
   import fft16_pkg::*;
   logic           start;
   logic           busy;
   logic           done;
   logic [SW-1:0]  stage;
   logic           rd_en;
   logic [AW-1:0]  rd_addr_a;
   logic [AW-1:0]  rd_addr_b;
   logic [TWW-1:0] tw_idx;
   logic           wr_en;
   logic [AW-1:0]  wr_addr_a;
   logic [AW-1:0]  wr_addr_b;
`ifdef FFT_SCHED_HOLD_EN
   logic           hold;
`endif
   modport master (
`ifdef FFT_SCHED_HOLD_EN
      input hold,
`endif
      input start,
      output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_idx, wr_en, wr_addr_a, wr_addr_b
   );
   modport slave (
`ifdef FFT_SCHED_HOLD_EN
      output hold,
`endif
      output start,
      input busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_idx, wr_en, wr_addr_a, wr_addr_b
   );
endinterface

// File: rtl/fft16_wr_delay.sv
// fft16_wr_delay: depth-D shift register of {valid, addr_a, addr_b} tracking butterflies to write-back
//   in_v/in_a/in_b: issued read; out_v/out_a/out_b: same values D cycles later
//   pend: a valid is still queued behind the output stage (D >= 2)
module fft16_wr_delay
   import fft16_pkg::*;
#(
   parameter int D = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_v,
   input  logic [AW-1:0] in_a,
   input  logic [AW-1:0] in_b,
   output logic          out_v,
   output logic [AW-1:0] out_a,
   output logic [AW-1:0] out_b,
   output logic          pend
);
   logic [D-1:0]         v;
   logic [D-1:0][AW-1:0] a, b;
   always_ff @(posedge clk)
      if (rst) begin
         v <= '0;
         a <= '0;
         b <= '0;
      end else begin
         v <= {v[D-2:0], in_v};
         a <= {a[D-2:0], in_a};
         b <= {b[D-2:0], in_b};
      end
   assign out_v = v[D-1];
   assign out_a = a[D-1];
   assign out_b = b[D-1];
   assign pend  = |v[D-2:0];
endmodule

// File: rtl/fft16_bfly_sched.sv
// fft16_bfly_sched: sequences one shared butterfly through a 16-point in-place radix-2 DIT FFT
//   clk, rst (sync, active-high); bus (master): start/hold in, busy/done/stage, read A/B + twiddle, write-back out
//   FFT_SCHED_HOLD_EN adds bus.hold, which stalls issue while in ISSUE
module fft16_bfly_sched
   import fft16_pkg::*;
#(
   parameter int MEM_RD_LAT = 1,
   parameter int BF_LAT     = 5
) (
   input logic                clk,
   input logic                rst,
   fft16_bfly_sched_if.master bus
);
   localparam int D = MEM_RD_LAT + BF_LAT;
   state_t         state, state_n;
   logic [SW-1:0]  stage_q, stage_n;
   logic [KW-1:0]  k_q, k_n;
   logic [AW-1:0]  a_q, a_n, b_q, b_n;
   logic [TWW-1:0] tw_q, tw_n;
   logic           rd_q, rd_n, busy_q, busy_n, done_q, done_n, hold, rd_en, pend;
`ifdef FFT_SCHED_HOLD_EN
   assign hold = bus.hold;
`else
   assign hold = 1'b0;
`endif
   // rd_q marks a valid butterfly on the address registers; hold masks it without losing it
   assign rd_en = rd_q & ~hold;
   always_ff @(posedge clk)
      if (rst) begin
         state   <= IDLE;
         stage_q <= '0;
         k_q     <= '0;
         rd_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         tw_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_n;
         stage_q <= stage_n;
         k_q     <= k_n;
         rd_q    <= rd_n;
         a_q     <= a_n;
         b_q     <= b_n;
         tw_q    <= tw_n;
         busy_q  <= busy_n;
         done_q  <= done_n;
      end
   // DRAIN exits in the cycle of the last write, so the next stage reads right after it
   always_comb begin
      state_n = state;
      stage_n = stage_q;
      k_n     = k_q;
      rd_n    = rd_q;
      busy_n  = busy_q;
      done_n  = 1'b0;
      case (state)
         IDLE:
            if (bus.start) begin
               state_n = ISSUE;
               stage_n = '0;
               k_n     = '0;
               rd_n    = 1'b1;
               busy_n  = 1'b1;
            end
         ISSUE:
            if (!hold) begin
               if (&k_q) begin
                  state_n = DRAIN;
                  rd_n    = 1'b0;
               end else
                  k_n = k_q + 1'b1;
            end
         DRAIN:
            if (!pend) begin
               if (&stage_q) begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  state_n = ISSUE;
                  stage_n = stage_q + 1'b1;
                  k_n     = '0;
                  rd_n    = 1'b1;
               end
            end
         default: state_n = IDLE;
      endcase
      a_n  = rd_n ? bf_addr_a(stage_n, k_n) : a_q;
      b_n  = rd_n ? bf_addr_b(stage_n, k_n) : b_q;
      tw_n = rd_n ? bf_tw(stage_n, k_n) : tw_q;
   end
   fft16_wr_delay #(.D(D)) u_dly (
      .clk   (clk),
      .rst   (rst),
      .in_v  (rd_en),
      .in_a  (a_q),
      .in_b  (b_q),
      .out_v (bus.wr_en),
      .out_a (bus.wr_addr_a),
      .out_b (bus.wr_addr_b),
      .pend  (pend)
   );
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.stage     = stage_q;
   assign bus.rd_en     = rd_en;
   assign bus.rd_addr_a = a_q;
   assign bus.rd_addr_b = b_q;
   assign bus.tw_idx    = tw_q;
endmodule
